instr_loader: RTL and testbench
===============================

# instr_loader

Program-load front end for the 3-stage pipelined ALU: the writer side of the 32×16 instruction memory that the fetch stage reads. It accepts a byte stream over a valid/ready handshake and packs byte pairs (high byte first) into 16-bit instructions, with fields op[15:12], a[11:4] and b[3:0]. It writes the packed words to sequential addresses from 0 and serves the fetch stage through a registered read port. It holds the core in reset until the program is loaded.

## Interface
Parameters:
- IW, 16, instruction width
- AW, 5, address width
- DEPTH, 32, number of instruction words

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- s_valid  in  1  input byte valid
- s_data  in  8  input byte
- s_last  in  1  marks the final byte of the program; qualified by s_valid
- s_ready  out  1  loader can accept a byte
- reload  in  1  single-cycle request to start a new load; honoured only in DONE
- fetch_addr  in  AW  fetch-stage read address (the pc)
- fetch_instr  out  IW  registered read data
- load_done  out  1  program loaded
- core_hold  out  1  always equal to !load_done; drives the pipeline reset
- word_count  out  AW+1  number of words written (0..32)
- err_odd  out  1  sticky: s_last arrived on a high byte
- err_overflow  out  1  sticky: a byte was accepted while memory was full

## Operation
- A byte transfers on any rising edge where s_valid && s_ready. The source holds s_data/s_last stable while s_valid && !s_ready.
- s_ready is a pure decode of the state: 1 in LOAD_HI, LOAD_LO and DRAIN; 0 in WRITE and DONE.
- FSM states: LOAD_HI, LOAD_LO, WRITE, DRAIN, DONE. Reset state is LOAD_HI.
- LOAD_HI:
  - On transfer, capture hi <= s_data and go to LOAD_LO.
  - If s_last=1 on that transfer, discard the byte, set err_odd and go to DONE.
- LOAD_LO:
  - On transfer, capture lo <= s_data and last_q <= s_last, then go to WRITE.
- WRITE (one cycle):
  - Write mem[wr_addr] <= {hi,lo}, then wr_addr++ and word_count++.
  - Next state: DONE if last_q; else DRAIN if the new word_count == DEPTH; else LOAD_HI.
- DRAIN:
  - Accept and discard bytes.
  - Every accepted byte sets err_overflow.
  - An accepted byte with s_last=1 goes to DONE.
  - Memory contents and word_count are unchanged.
- DONE:
  - load_done=1.
  - reload=1 clears wr_addr, word_count, err_odd and err_overflow, and goes to LOAD_HI.
  - Memory is not cleared; new words overwrite from address 0.
  - reload is ignored in every other state.
- Memory and address rules:
  - Memory is cleared to 0 on reset, so unwritten entries read as 0x0000 (op 0).
  - wr_addr never wraps; DRAIN prevents a 33rd write.
- Fetch read:
  - fetch_instr <= mem[fetch_addr] every cycle, in every state.
  - If the read and a write hit the same address in the same cycle, fetch_instr returns the old data.

## Timing
- Reset values (applied asynchronously on reset=0):
  - state LOAD_HI, so s_ready=1
  - load_done=0, core_hold=1
  - word_count=0, err_odd=0, err_overflow=0
  - fetch_instr=0, all memory words 0
- Reset mid-load: the partial word is lost, all outputs return to reset values, and loading restarts at address 0.
- Word throughput: 3 cycles per word minimum (hi, lo, write). The cycle with s_ready=0 in WRITE is the only backpressure.
- load_done rises on the edge that leaves WRITE (or LOAD_HI/DRAIN) for DONE, and falls on the edge that accepts reload.
- The write to memory and the word_count increment occur on the same edge.
- Read latency: 1 cycle from fetch_addr to fetch_instr.
- Error flags assert on the edge of the offending transfer and stay set until reset or reload.

## Structure
- Shared package instr_pkg:
  - constants IW, AW, DEPTH
  - field ranges OP_HI/OP_LO (15:12), A_HI/A_LO (11:4), B_HI/B_LO (3:0)
  - state encoding for LOAD_HI/LOAD_LO/WRITE/DRAIN/DONE
- Sub-module instr_ram: DEPTH×IW memory with one write port, one registered read port and asynchronous clear. The pipeline's fetch stage instantiates the same block.
- The FSM, hi/lo/last_q registers, address counter and error flags live in instr_loader.

## Test plan
- Basic load: bytes 0x12, 0x34, 0x56, 0x78 (last on 0x78), streamed back-to-back -> mem[0]=0x1234, mem[1]=0x5678, word_count=2, load_done=1, core_hold=0. A read of fetch_addr=1 returns 0x5678 one cycle later, and fetch_addr=2 returns 0x0000.
- Odd length: 0x12, 0x34, then 0xAB with last -> err_odd=1, word_count=1, mem[1] still 0x0000, load_done=1.
- Overflow: 64 bytes with no last, then 0xFF and 0xEE (last on 0xEE) -> word_count=32, FSM enters DRAIN after the 32nd write, err_overflow=1, mem[0..31] intact, load_done=1.
- Backpressure: s_valid held high with new data presented during WRITE (s_ready=0) -> that byte is accepted the following cycle, not dropped or duplicated. Random s_valid gaps -> identical memory image to the back-to-back run.
- Reset mid-load: assert reset=0 after 3 bytes -> all outputs take reset values immediately. Reload 0xA1, 0xB2 (last) -> mem[0]=0xA1B2, word_count=1.
- Reload: in DONE with word_count=2, pulse reload and load 0xCAFE (last) while fetch_addr=0 -> counters and errors clear, mem[0]=0xCAFE, mem[1] keeps its old value. fetch_instr shows the old mem[0] in the write cycle and 0xCAFE one cycle after.

Source files
------------

// File: rtl/instr_pkg.sv
// Shared definitions for the instruction memory and its program loader.
//   IW/AW/DEPTH  : instruction width, address width, word count
//   OP/A/B_*     : instruction field bit ranges (op[15:12], a[11:4], b[3:0])
//   state_t      : loader FSM encoding
//   pack_instr   : byte pair -> instruction word, high byte first
package instr_pkg;
  localparam int IW    = 16;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int A_HI  = 11;
  localparam int A_LO  = 4;
  localparam int B_HI  = 3;
  localparam int B_LO  = 0;

  typedef enum logic [2:0] {
    LOAD_HI = 3'd0,
    LOAD_LO = 3'd1,
    WRITE   = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  function automatic logic [IW-1:0] pack_instr(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/instr_ram.sv
// DEPTH x IW instruction memory: one write port, one registered read port,
// asynchronous clear of every word and of the read register.
//   clk, reset      : clock, async active-low clear
//   we/waddr/wdata  : write port
//   raddr/rdata     : read port, rdata valid one cycle after raddr
// A read and write to the same address in one cycle returns the old word.
module instr_ram
  import instr_pkg::*;
#(
  parameter int IW    = instr_pkg::IW,
  parameter int AW    = instr_pkg::AW,
  parameter int DEPTH = instr_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/instr_loader.sv
// Program-load front end: packs a byte stream (high byte first) into
// instruction words, writes them from address 0 and holds the core in
// reset until the program is in memory.
//   s_valid/s_data/s_last/s_ready : byte stream handshake
//   reload                        : restart a load, only honoured in DONE
//   fetch_addr/fetch_instr        : fetch-stage read port, 1-cycle latency
//   load_done/core_hold           : load complete / pipeline reset
//   word_count                    : words written (0..DEPTH)
//   err_odd/err_overflow          : sticky stream errors
module instr_loader
  import instr_pkg::*;
#(
  parameter int IW    = instr_pkg::IW,
  parameter int AW    = instr_pkg::AW,
  parameter int DEPTH = instr_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          reload,
  input  logic [AW-1:0] fetch_addr,
  output logic [IW-1:0] fetch_instr,
  output logic          load_done,
  output logic          core_hold,
  output logic [AW:0]   word_count,
  output logic          err_odd,
  output logic          err_overflow
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [7:0]    hi, lo;
  logic          last_q;
  logic [AW-1:0] wr_addr;
  logic          xfer, full_next;

  // Outputs are pure decodes of the registered state.
  assign s_ready   = (state == LOAD_HI) || (state == LOAD_LO) || (state == DRAIN);
  assign load_done = (state == DONE);
  assign core_hold = !load_done;
  assign xfer      = s_valid && s_ready;
  assign full_next = (word_count + 1'b1) == DEPTH_W;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LOAD_HI;
      hi           <= '0;
      lo           <= '0;
      last_q       <= 1'b0;
      wr_addr      <= '0;
      word_count   <= '0;
      err_odd      <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state)
        LOAD_HI: if (xfer) begin
          if (s_last) begin
            err_odd <= 1'b1;   // a lone high byte cannot form a word
            state   <= DONE;
          end else begin
            hi    <= s_data;
            state <= LOAD_LO;
          end
        end
        LOAD_LO: if (xfer) begin
          lo     <= s_data;
          last_q <= s_last;
          state  <= WRITE;
        end
        WRITE: begin
          word_count <= word_count + 1'b1;
          // Hold the address on the final slot so it never wraps.
          if (!full_next) wr_addr <= wr_addr + 1'b1;
          if (last_q)         state <= DONE;
          else if (full_next) state <= DRAIN;
          else                state <= LOAD_HI;
        end
        DRAIN: if (xfer) begin
          err_overflow <= 1'b1;
          if (s_last) state <= DONE;
        end
        DONE: if (reload) begin
          wr_addr      <= '0;
          word_count   <= '0;
          err_odd      <= 1'b0;
          err_overflow <= 1'b0;
          state        <= LOAD_HI;
        end
        default: state <= LOAD_HI;
      endcase
    end
  end

  instr_ram #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (state == WRITE),
    .waddr (wr_addr),
    .wdata (pack_instr(hi, lo)),
    .raddr (fetch_addr),
    .rdata (fetch_instr)
  );
endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  import instr_pkg::*;

  logic          clk = 0, reset = 0;
  logic          s_valid = 0, s_last = 0, reload = 0;
  logic [7:0]    s_data = 0;
  logic [AW-1:0] fetch_addr = 0;
  logic          s_ready, load_done, core_hold, err_odd, err_overflow;
  logic [IW-1:0] fetch_instr;
  logic [AW:0]   word_count;

  instr_loader dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .reload(reload), .fetch_addr(fetch_addr), .fetch_instr(fetch_instr),
    .load_done(load_done), .core_hold(core_hold), .word_count(word_count),
    .err_odd(err_odd), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  typedef struct {logic [AW-1:0] addr; logic [IW-1:0] word;} sb_t;
  typedef struct {logic [AW-1:0] addr; logic [IW-1:0] exp;} vec_t;
  sb_t        exp_q[$];
  logic [7:0] prog[$];
  vec_t       vt[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Present a byte and return just after the edge that transfers it.
  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    s_valid = 1; s_data = d; s_last = l;
    while (!s_ready && n < 20) begin step(); n++; end
    if (!s_ready) begin check("send_timeout", 0, 1); s_valid = 0; end
    else step();
  endtask

  // Stream prog, pushing each expected word to the scoreboard as it is sent.
  task automatic send_prog(input bit with_last, input bit gaps);
    for (int i = 0; i < prog.size(); i++) begin
      send_byte(prog[i], with_last && (i == prog.size() - 1));
      if (i % 2 == 1) exp_q.push_back('{AW'(i / 2), {prog[i-1], prog[i]}});
      if (gaps && $urandom_range(0, 1) == 1) begin
        s_valid = 0;
        repeat ($urandom_range(1, 3)) step();
      end
    end
    s_valid = 0; s_last = 0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!load_done && n < 50) begin step(); n++; end
    check("wait_done", load_done, 1);
  endtask

  task automatic check_sb();
    while (exp_q.size() > 0) begin
      sb_t e;
      e = exp_q.pop_front();
      fetch_addr = e.addr;
      step();
      check($sformatf("mem[%0d]", e.addr), fetch_instr, e.word);
    end
  endtask

  task automatic do_reload();
    reload = 1; step(); reload = 0;
    check("reload_clears_done", load_done, 0);
    check("reload_clears_wc", word_count, 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 0; #2 reset = 1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{5'd1,  16'h5678};
    vt[1] = '{5'd2,  16'h0000};
    vt[2] = '{5'd0,  16'h1234};
    vt[3] = '{5'd31, 16'h0000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", s_ready, 1);
    check("rst_done", load_done, 0);
    check("rst_hold", core_hold, 1);
    check("rst_wc", word_count, 0);
    check("rst_odd", err_odd, 0);
    check("rst_ovf", err_overflow, 0);
    check("rst_instr", fetch_instr, 0);
    reset = 1;
    step();

    // Basic load, back-to-back
    prog.delete();
    prog.push_back(8'h12); prog.push_back(8'h34); prog.push_back(8'h56); prog.push_back(8'h78);
    send_prog(1, 0);
    wait_done();
    check("basic_wc", word_count, 2);
    check("basic_hold", core_hold, 0);
    check("basic_odd", err_odd, 0);
    check_sb();
    for (int i = 0; i < 4; i++) begin
      fetch_addr = vt[i].addr;
      step();
      check($sformatf("vec%0d_addr%0d", i, vt[i].addr), fetch_instr, vt[i].exp);
    end

    // Reload 0xCAFE with fetch_addr=0: old data during the write cycle
    fetch_addr = 0;
    do_reload();
    check("reload_ready", s_ready, 1);
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 1);
    s_valid = 0; s_last = 0;
    check("reload_in_write", s_ready, 0);
    step();
    check("reload_old_rd", fetch_instr, 16'h1234);
    check("reload_done", load_done, 1);
    check("reload_wc", word_count, 1);
    step();
    check("reload_new_rd", fetch_instr, 16'hCAFE);
    fetch_addr = 1;
    step();
    check("reload_mem1_kept", fetch_instr, 16'h5678);

    // Backpressure: next byte held through the WRITE cycle
    do_reload();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    s_data = 8'h33; s_last = 0;
    check("bp_stall", s_ready, 0);
    step();
    check("bp_ready_again", s_ready, 1);
    check("bp_wc1", word_count, 1);
    step();  // 0x33 transfers here
    send_byte(8'h44, 1);
    s_valid = 0; s_last = 0;
    wait_done();
    check("bp_wc2", word_count, 2);
    exp_q.push_back('{5'd0, 16'h1122});
    exp_q.push_back('{5'd1, 16'h3344});
    check_sb();

    // Same program back-to-back and with random gaps
    for (int pass = 0; pass < 2; pass++) begin
      do_reload();
      prog.delete();
      for (int i = 0; i < 8; i++) prog.push_back(8'(8'hA0 + 8'(i * 7)));
      send_prog(1, pass == 1);
      wait_done();
      check($sformatf("gap%0d_wc", pass), word_count, 4);
      check_sb();
    end

    // Reset mid-load
    do_reload();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    s_valid = 0;
    check("mid_wc_before", word_count, 1);
    #2 reset = 0;
    #1;
    check("mid_rst_wc", word_count, 0);
    check("mid_rst_ready", s_ready, 1);
    check("mid_rst_hold", core_hold, 1);
    check("mid_rst_instr", fetch_instr, 0);
    @(posedge clk); #2 reset = 1;
    step();
    prog.delete();
    prog.push_back(8'hA1); prog.push_back(8'hB2);
    send_prog(1, 0);
    wait_done();
    check("mid_wc", word_count, 1);
    check_sb();

    // Odd length on fresh memory
    pulse_reset();
    prog.delete();
    prog.push_back(8'h12); prog.push_back(8'h34); prog.push_back(8'hAB);
    send_prog(1, 0);
    wait_done();
    check("odd_flag", err_odd, 1);
    check("odd_wc", word_count, 1);
    check_sb();
    fetch_addr = 1;
    step();
    check("odd_mem1", fetch_instr, 0);

    // Overflow: 32 full words then two drained bytes
    do_reload();
    check("ovf_odd_cleared", err_odd, 0);
    prog.delete();
    for (int i = 0; i < 64; i++) prog.push_back(8'(i));
    send_prog(0, 0);
    step();
    check("ovf_drain_ready", s_ready, 1);
    check("ovf_wc32", word_count, 32);
    check("ovf_not_done", load_done, 0);
    check("ovf_flag_clear", err_overflow, 0);
    reload = 1; step(); reload = 0;
    check("ovf_reload_ignored", word_count, 32);
    send_byte(8'hFF, 0);
    check("ovf_flag", err_overflow, 1);
    check("ovf_still_drain", load_done, 0);
    send_byte(8'hEE, 1);
    s_valid = 0; s_last = 0;
    check("ovf_done", load_done, 1);
    check("ovf_wc_final", word_count, 32);
    check_sb();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
